// File: rtl/mos6502_bus_pkg.sv
// Shared encodings and request tuple for the tinymos6502 bus demultiplexer.
package mos6502_bus_pkg;

    localparam logic [1:0] PH_CTRL    = 2'd0;
    localparam logic [1:0] PH_ADDR_LO = 2'd1;
    localparam logic [1:0] PH_ADDR_HI = 2'd2;

    localparam int RW_BIT   = 0;
    localparam int SYNC_BIT = 1;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        sync;
    } bus_req_t;

endpackage

// File: rtl/mos6502_frame_capture.sv
// Tracks the 3-phase mux bus, captures address bytes and flags completed frames.
module mos6502_frame_capture
    import mos6502_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       align,
    input  logic [7:0] mux_bus,
    input  logic [7:0] data_out,
    input  logic [7:0] data_oe,
    output logic       frame_done,
    output bus_req_t   frame,
    output logic       frame_valid
);

    logic [1:0] phase;
    logic       primed;
    logic [7:0] addr_lo;
    logic [7:0] addr_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= PH_CTRL;
            primed      <= 1'b0;
            addr_lo     <= 8'h00;
            addr_hi     <= 8'h00;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (phase == PH_ADDR_LO) addr_lo <= mux_bus;
            if (phase == PH_ADDR_HI) addr_hi <= mux_bus;
            if (align) begin
                phase  <= PH_CTRL;
                primed <= 1'b0;
            end else begin
                case (phase)
                    PH_ADDR_LO: phase <= PH_ADDR_HI;
                    PH_ADDR_HI: begin
                        phase  <= PH_CTRL;
                        primed <= 1'b1;
                    end
                    default:    phase <= PH_ADDR_LO;
                endcase
            end
        end
    end

    // The control phase is taken straight off the bus on the completing edge.
    assign frame_done  = (phase == PH_CTRL) && primed && !align;
    assign frame.addr  = {addr_hi, addr_lo};
    assign frame.we    = ~mux_bus[RW_BIT];
    assign frame.wdata = (data_oe == 8'hFF) ? data_out : 8'h00;
    assign frame.sync  = mux_bus[SYNC_BIT];

endmodule

// File: rtl/mos6502_bus_demux.sv
// Turns completed bus frames into one req/ack memory request per CPU cycle.
module mos6502_bus_demux
    import mos6502_bus_pkg::*;
#(
    parameter int         FRAMES_PER_CYCLE = 2,
    parameter logic [7:0] RESET_RDATA      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cpu_mux_bus,
    input  logic [7:0]  cpu_data_out,
    input  logic [7:0]  cpu_data_oe,
    output logic [7:0]  cpu_data_in,
    input  logic        align,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        mem_sync,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        frame_valid,
    output logic        overrun
);

    localparam int CW = (FRAMES_PER_CYCLE > 1) ? $clog2(FRAMES_PER_CYCLE) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   frame_cnt;
    logic            frame_done;
    bus_req_t        frame;
    bus_req_t        req;
    logic            new_req, load, ack_ok, ovr_set;

    mos6502_frame_capture u_cap (
        .clk        (clk),
        .rst        (rst),
        .align      (align),
        .mux_bus    (cpu_mux_bus),
        .data_out   (cpu_data_out),
        .data_oe    (cpu_data_oe),
        .frame_done (frame_done),
        .frame      (frame),
        .frame_valid(frame_valid)
    );

    assign new_req = frame_done && (frame_cnt == '0);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        ack_ok     = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            IDLE: if (new_req) begin
                load       = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                if (mem_ack) begin
                    // Completing ack frees the slot for a request landing on the same edge.
                    ack_ok = 1'b1;
                    if (new_req) load = 1'b1;
                    else         state_next = IDLE;
                end else if (new_req) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            frame_cnt   <= '0;
            req         <= '0;
            cpu_data_in <= RESET_RDATA;
            overrun     <= 1'b0;
        end else begin
            state <= state_next;
            if (align)
                frame_cnt <= '0;
            else if (frame_done)
                frame_cnt <= (frame_cnt == CW'(FRAMES_PER_CYCLE - 1)) ? '0 : frame_cnt + 1'b1;
            if (load)               req         <= frame;
            if (ack_ok && !req.we)  cpu_data_in <= mem_rdata;
            if (ovr_set)            overrun     <= 1'b1;
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_addr  = req.addr;
    assign mem_we    = req.we;
    assign mem_wdata = req.wdata;
    assign mem_sync  = req.sync;

endmodule

// File: tb/tb_mos6502_bus_demux.sv
// Directed and randomized checks of mos6502_bus_demux against a cycle-count reference model.
module tb_mos6502_bus_demux;

    localparam int         F   = 2;
    localparam logic [7:0] RRD = 8'h3C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cpu_mux_bus = 8'h00, cpu_data_out = 8'h00, cpu_data_oe = 8'h00;
    logic [7:0]  cpu_data_in;
    logic        align = 1'b0;
    logic        mem_req, mem_we, mem_sync, frame_valid, overrun;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  rdata_v = 8'h00;

    int vectors = 0, miscompares = 0;

    // Reference model: edges counted since reset/align, frames counted since align.
    int          ticks, frames;
    logic        have_hi, exp_fv, exp_req, exp_we, exp_sync, exp_ovr;
    logic [7:0]  lo, hi, exp_wdata, exp_cpu;
    logic [15:0] exp_addr;

    mos6502_bus_demux #(.FRAMES_PER_CYCLE(F), .RESET_RDATA(RRD)) dut (
        .clk(clk), .rst(rst), .cpu_mux_bus(cpu_mux_bus), .cpu_data_out(cpu_data_out),
        .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in), .align(align),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_sync(mem_sync), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .frame_valid(frame_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ticks = 0; frames = 0; have_hi = 1'b0; exp_fv = 1'b0; exp_req = 1'b0;
        exp_ovr = 1'b0; exp_cpu = RRD; lo = 8'h00; hi = 8'h00;
    endtask

    task automatic model_edge();
        logic nreq;
        int   ph;
        nreq   = 1'b0;
        exp_fv = 1'b0;
        if (align) begin
            ticks = 0; frames = 0; have_hi = 1'b0;
        end else begin
            ph = ticks % 3;
            if (ph == 1) lo = cpu_mux_bus;
            if (ph == 2) begin hi = cpu_mux_bus; have_hi = 1'b1; end
            if (ph == 0 && have_hi) begin
                exp_fv = 1'b1;
                nreq   = (frames % F) == 0;
                frames++;
            end
            ticks++;
        end
        if (exp_req && mem_ack) begin
            if (!exp_we) exp_cpu = mem_rdata;
            exp_req = 1'b0;
        end
        if (nreq) begin
            if (!exp_req) begin
                exp_req   = 1'b1;
                exp_addr  = {hi, lo};
                exp_we    = ~cpu_mux_bus[0];
                exp_sync  = cpu_mux_bus[1];
                exp_wdata = (cpu_data_oe == 8'hFF) ? cpu_data_out : 8'h00;
            end else begin
                exp_ovr = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("frame_valid", frame_valid, exp_fv);
        chk("mem_req", mem_req, exp_req);
        chk("overrun", overrun, exp_ovr);
        chk("cpu_data_in", cpu_data_in, exp_cpu);
        if (exp_req) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", mem_we, exp_we);
            chk("mem_wdata", mem_wdata, exp_wdata);
            chk("mem_sync", mem_sync, exp_sync);
        end
    endtask

    task automatic step(input logic [7:0] bus, input logic [7:0] dout, input logic [7:0] oe,
                        input logic aln, input logic ack);
        @(negedge clk);
        cpu_mux_bus = bus; cpu_data_out = dout; cpu_data_oe = oe;
        align = aln; mem_ack = ack; mem_rdata = rdata_v;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    // Three edges, each presenting the byte that belongs to the phase the model expects.
    task automatic drive_frame(input logic [7:0] a_lo, input logic [7:0] a_hi, input logic rw,
                               input logic sy, input logic [7:0] dout, input logic [7:0] oe,
                               input logic ack_early, input logic ack_ctrl);
        for (int k = 0; k < 3; k++) begin
            case (ticks % 3)
                1:       step(a_lo, dout, oe, 1'b0, ack_early);
                2:       step(a_hi, dout, oe, 1'b0, ack_early);
                default: step({6'b0, sy, rw}, dout, oe, 1'b0, ack_ctrl);
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; mem_ack = 1'b0; align = 1'b0;
        #1;
        chk("rst_async_req", mem_req, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_mem_sync", mem_sync, 1'b0);
        chk("rst_frame_valid", frame_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_cpu_data_in", cpu_data_in, RRD);

        // Read cycle after align, acked on the next edge.
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive_frame(8'h34, 8'h12, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("rd_req", mem_req, 1'b1);
        chk("rd_addr", mem_addr, 16'h1234);
        chk("rd_we", mem_we, 1'b0);
        chk("rd_sync", mem_sync, 1'b1);
        rdata_v = 8'hA9;
        drive_frame(8'h34, 8'h12, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("rd_data", cpu_data_in, 8'hA9);
        chk("rd_done", mem_req, 1'b0);

        // Write cycles with and without qualified output enable.
        drive_frame(8'hFE, 8'hFF, 1'b0, 1'b0, 8'h5A, 8'hFF, 1'b0, 1'b0);
        chk("wr_we", mem_we, 1'b1);
        chk("wr_wdata", mem_wdata, 8'h5A);
        chk("wr_addr", mem_addr, 16'hFFFE);
        drive_frame(8'hFE, 8'hFF, 1'b0, 1'b0, 8'h5A, 8'hFF, 1'b1, 1'b0);
        drive_frame(8'hFE, 8'hFF, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0);
        chk("wr_oe0_wdata", mem_wdata, 8'h00);
        chk("wr_oe0_req", mem_req, 1'b1);
        drive_frame(8'hFE, 8'hFF, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0);
        chk("wr_cpu_hold", cpu_data_in, 8'hA9);

        // Ack lands on the edge that completes the next cycle's first frame.
        drive_frame(8'h00, 8'h40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive_frame(8'h00, 8'h40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        rdata_v = 8'h66;
        drive_frame(8'h02, 8'h40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("sim_req", mem_req, 1'b1);
        chk("sim_addr", mem_addr, 16'h4002);
        chk("sim_overrun", overrun, 1'b0);
        chk("sim_rdata", cpu_data_in, 8'h66);
        drive_frame(8'h02, 8'h40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Ack withheld across two CPU cycles.
        drive_frame(8'h11, 8'h22, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive_frame(8'h11, 8'h22, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive_frame(8'h33, 8'h44, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_addr", mem_addr, 16'h2211);
        drive_frame(8'h33, 8'h44, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("ovr_addr_hold", mem_addr, 16'h2211);

        // Reset while a request is outstanding.
        do_reset();

        // Align in the middle of a frame; the partial frame must not surface.
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h77, 8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h88, 8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("aln_no_fv", frame_valid, 1'b0);
        chk("aln_no_req", mem_req, 1'b0);
        drive_frame(8'hCD, 8'hAB, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("aln_fv", frame_valid, 1'b1);
        chk("aln_addr", mem_addr, 16'hABCD);

        // Randomized traffic with occasional align.
        for (int i = 0; i < 900; i++) begin
            rdata_v = 8'($urandom);
            step(8'($urandom), 8'($urandom),
                 ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mos6502_bus_demux.md
Name: mos6502_bus_demux

Overview:
- Board/FPGA-side partner of the tinymos6502 chip top. Reconstructs the 3-phase time-multiplexed output bus (addr low, addr high, RW/SYNC) into a full 16-bit address plus control.
- Issues one memory request per CPU cycle over a req/ack handshake. Returns read data on the chip's bidirectional data input and captures write data from the chip's data output.
- Runs on the same `clk` as the chip, reset together with it, so the phase counters stay in lockstep.

Parameters:
- FRAMES_PER_CYCLE, 2, frames per 6502 clock period (CPU clock toggles once per frame).
- RESET_RDATA, 8'h00, value driven on cpu_data_in after reset.

Ports:
- clk  input  1  system clock, same as chip `clk`
- rst  input  1  asynchronous active-high reset
- cpu_mux_bus  input  8  chip `uo_out`
- cpu_data_out  input  8  chip `uio_out`
- cpu_data_oe  input  8  chip `uio_oe`
- cpu_data_in  output  8  drives chip `uio_in`
- align  input  1  synchronous pulse; forces phase counter to 0 and frame counter to 0 on the next edge
- mem_req  output  1  request valid
- mem_addr  output  16  request address
- mem_we  output  1  1 = write (RW==0)
- mem_wdata  output  8  write data
- mem_sync  output  1  opcode-fetch marker (SYNC)
- mem_ack  input  1  request accepted/completed this cycle
- mem_rdata  input  8  read data, valid with mem_ack when mem_we==0
- frame_valid  output  1  one-clk pulse when a frame completes
- overrun  output  1  sticky: a cycle request was dropped

Behaviour:
- Reset values: all outputs 0 except cpu_data_in = RESET_RDATA. phase=0, frame_cnt=0, primed=0.
- Phase counter: 0→1→2→0 on every clk; align overrides.
- Samples are taken on the rising edge while phase==1 (addr_lo <= cpu_mux_bus), phase==2 (addr_hi), and phase==0 (rw <= bit0, sync <= bit1, wdata <= cpu_data_out).
- Each sample reflects the value the chip registered one clk earlier.
- The phase-0 edge completes a frame only if primed==1. primed sets on the first phase-2 edge after reset or align, so the first partial frame is discarded.
- Frame completion:
  - Assert frame_valid for 1 clk.
  - frame_cnt increments mod FRAMES_PER_CYCLE.
  - When frame_cnt==0 (first frame of a CPU cycle), the captured tuple becomes a request.
- Request FSM, states IDLE and BUSY:
  - IDLE + new request: load mem_addr/mem_we(=~rw)/mem_wdata/mem_sync, set mem_req=1, go to BUSY. mem_req is visible on the clock after the completing edge.
  - BUSY + mem_ack: mem_req=0, go to IDLE. If mem_we==0, latch mem_rdata into cpu_data_in.
  - Request fields are stable while mem_req==1.
  - mem_ack while IDLE is ignored.
  - cpu_data_in holds its value until the next read ack.
- Write-data qualification: mem_wdata is taken from cpu_data_out only if cpu_data_oe==8'hFF at the phase-0 sample. Otherwise mem_wdata = 8'h00 and the request is still issued.
- Simultaneous ack and new request in BUSY: the ack completes the old request and the new one loads on the same edge; mem_req stays 1.
- New request while BUSY with no ack: drop the new request, set overrun=1 (sticky until rst), keep the current request.
- align during BUSY: the outstanding request stays until acked; the capture registers restart.
- rst mid-request: mem_req drops immediately (async); no ack is expected afterwards.

Decomposition:
- Shared package `mos6502_bus_pkg`:
  - phase encodings PH_ADDR_LO=1, PH_ADDR_HI=2, PH_CTRL=0
  - control bit positions RW_BIT=0, SYNC_BIT=1
  - typedef bus_req_t {addr[15:0], we, wdata[7:0], sync}
- One sub-module `mos6502_frame_capture`: phase counter, align, primed logic, field capture, and frame_valid. The top holds frame_cnt, the request FSM, and the read-data latch.

Test Plan:
- Reset → all outputs 0, cpu_data_in=RESET_RDATA; rst asserted while mem_req=1 → mem_req=0 the same clk.
- Drive bus 34,12,(RW=1,SYNC=1) in phases 1,2,0 twice after align; ack immediately with mem_rdata=A9 → exactly one mem_req, mem_addr=1234, mem_we=0, mem_sync=1, cpu_data_in=A9 after ack.
- Write cycle: addr FFFE, ctrl RW=0, cpu_data_out=5A, oe=FF → mem_we=1, mem_wdata=5A. Repeat with oe=00 → mem_wdata=00.
- Withhold mem_ack across two CPU cycles → first request held stable, overrun=1, second address never appears on mem_addr.
- Ack on the same edge a new cycle completes → mem_req stays high, mem_addr updates to the new address, overrun=0.
- Pulse align mid-frame → no frame_valid until a full phase 1/2/0 sequence is captured; the partial frame is never requested.
